// File: rtl/board_game_pkg.sv
// Shared encodings for the N x N board game controller: cells, status, FSM states, scan directions.
package board_game_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_X_WON   = 2'b01;
  localparam logic [1:0] ST_O_WON   = 2'b10;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  // Scan order: horizontal, vertical, diagonal, anti-diagonal (row, col deltas)
  localparam logic [1:0] DIR_LAST = 2'd3;
  localparam int DIR_DR [4] = '{0, 1, 1, 1};
  localparam int DIR_DC [4] = '{1, 0, 1, -1};

  function automatic logic [1:0] player_cell(input logic turn);
    return turn ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/bgc_line_count.sv
// Combinational run length of one player's cells through an origin along one direction.
module bgc_line_count
  import board_game_pkg::*;
#(
  parameter  int unsigned N       = 3,
  parameter  int unsigned WIN_LEN = 3,
  localparam int unsigned CW      = $clog2(N),
  localparam int unsigned LW      = $clog2(WIN_LEN + 1)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [CW-1:0]    org_row,
  input  logic [CW-1:0]    org_col,
  input  logic [1:0]       dir,
  input  logic [1:0]       player,
  output logic [LW-1:0]    run_len,
  output logic [CW-1:0]    start_row,
  output logic [CW-1:0]    start_col
);

  localparam int unsigned NN = N * N;
  localparam int unsigned IW = $clog2(NN);
  localparam int NI = int'(N);
  localparam int WL = int'(WIN_LEN);

  logic [1:0] cells [NN];

  for (genvar g = 0; g < NN; g++) begin : g_cells
    assign cells[g] = board[2*g +: 2];
  end

  int dr, dc, back, fwd, r, c, total;
  logic go_b, go_f;
  logic [IW-1:0] idx;

  // Walk backwards then forwards from the origin, stopping at the edge or a foreign cell
  always_comb begin
    dr    = DIR_DR[dir];
    dc    = DIR_DC[dir];
    back  = 0;
    fwd   = 0;
    go_b  = 1'b1;
    go_f  = 1'b1;
    r     = 0;
    c     = 0;
    idx   = '0;
    for (int k = 1; k < WL; k++) begin
      r = int'(org_row) - k * dr;
      c = int'(org_col) - k * dc;
      if (go_b && r >= 0 && r < NI && c >= 0 && c < NI) begin
        idx = IW'(r * NI + c);
        if (cells[idx] == player) back = k;
        else go_b = 1'b0;
      end else begin
        go_b = 1'b0;
      end
    end
    for (int k = 1; k < WL; k++) begin
      r = int'(org_row) + k * dr;
      c = int'(org_col) + k * dc;
      if (go_f && r >= 0 && r < NI && c >= 0 && c < NI) begin
        idx = IW'(r * NI + c);
        if (cells[idx] == player) fwd = k;
        else go_f = 1'b0;
      end else begin
        go_f = 1'b0;
      end
    end
    total     = 1 + back + fwd;
    run_len   = (total >= WL) ? LW'(WL) : LW'(total);
    // The backward end is always the lowest board index of the run
    start_row = CW'(int'(org_row) - back * dr);
    start_col = CW'(int'(org_col) - back * dc);
  end

endmodule

// File: rtl/board_game_ctrl.sv
// Two-player N x N K-in-a-row game controller with move handshake and sequential win scan.
// Optional single-depth undo when BGC_UNDO_EN is defined.
module board_game_ctrl
  import board_game_pkg::*;
#(
  parameter  int unsigned N       = 3,
  parameter  int unsigned WIN_LEN = 3,
  localparam int unsigned CW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
`ifdef BGC_UNDO_EN
  input  logic             undo,
`endif
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [CW-1:0]    move_row,
  input  logic [CW-1:0]    move_col,
  output logic [2*N*N-1:0] board,
  output logic             turn,
  output logic [1:0]       status,
  output logic             illegal,
  output logic [N*N-1:0]   win_cells
);

  localparam int unsigned NN  = N * N;
  localparam int unsigned IW  = $clog2(NN);
  localparam int unsigned CNW = $clog2(NN + 1);
  localparam int unsigned LW  = $clog2(WIN_LEN + 1);
  localparam int NI = int'(N);
  localparam int WL = int'(WIN_LEN);

  logic [1:0]     state_q, state_d;
  logic [1:0]     cells_q [NN];
  logic [1:0]     cells_d [NN];
  logic           turn_q, turn_d;
  logic [1:0]     status_q, status_d;
  logic           illegal_q, illegal_d;
  logic [NN-1:0]  win_q, win_d;
  logic           ready_q, ready_d;
  logic [CW-1:0]  mv_row_q, mv_row_d;
  logic [CW-1:0]  mv_col_q, mv_col_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [1:0]     dir_q, dir_d;
`ifdef BGC_UNDO_EN
  logic           undo_avail_q, undo_avail_d;
  logic [IW-1:0]  last_idx;
`endif

  logic           mv_in_range, mv_legal;
  logic [IW-1:0]  mv_idx;
  int             wr, wc;

  logic [LW-1:0]  lc_len;
  logic [CW-1:0]  lc_start_row, lc_start_col;

  for (genvar g = 0; g < NN; g++) begin : g_board
    assign board[2*g +: 2] = cells_q[g];
  end

  assign move_ready = ready_q;
  assign turn       = turn_q;
  assign status     = status_q;
  assign illegal    = illegal_q;
  assign win_cells  = win_q;

  bgc_line_count #(
    .N       (N),
    .WIN_LEN (WIN_LEN)
  ) u_line_count (
    .board     (board),
    .org_row   (mv_row_q),
    .org_col   (mv_col_q),
    .dir       (dir_q),
    .player    (player_cell(turn_q)),
    .run_len   (lc_len),
    .start_row (lc_start_row),
    .start_col (lc_start_col)
  );

  // Next-state and register-input logic
  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    turn_d    = turn_q;
    status_d  = status_q;
    illegal_d = 1'b0;
    win_d     = win_q;
    mv_row_d  = mv_row_q;
    mv_col_d  = mv_col_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    wr        = 0;
    wc        = 0;
`ifdef BGC_UNDO_EN
    undo_avail_d = undo_avail_q;
    last_idx     = IW'(int'(mv_row_q) * NI + int'(mv_col_q));
`endif
    mv_in_range = (int'(move_row) < NI) && (int'(move_col) < NI);
    mv_idx      = IW'(int'(move_row) * NI + int'(move_col));
    mv_legal    = mv_in_range && (cells_q[mv_idx] == CELL_EMPTY);

    if (new_game) begin
      state_d  = S_IDLE;
      cells_d  = '{default: CELL_EMPTY};
      turn_d   = 1'b0;
      status_d = ST_PLAYING;
      win_d    = '0;
      cnt_d    = '0;
      dir_d    = '0;
`ifdef BGC_UNDO_EN
      undo_avail_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (move_valid && ready_q) begin
            if (mv_legal) begin
              cells_d[mv_idx] = player_cell(turn_q);
              mv_row_d = move_row;
              mv_col_d = move_col;
              cnt_d    = cnt_q + CNW'(1);
              dir_d    = '0;
              state_d  = S_SCAN;
`ifdef BGC_UNDO_EN
              undo_avail_d = 1'b1;
`endif
            end else begin
              illegal_d = 1'b1;
            end
          end
`ifdef BGC_UNDO_EN
          else if (undo && undo_avail_q && status_q == ST_PLAYING && cnt_q != '0) begin
            cells_d[last_idx] = CELL_EMPTY;
            cnt_d        = cnt_q - CNW'(1);
            turn_d       = ~turn_q;
            undo_avail_d = 1'b0;
          end
`endif
        end
        S_SCAN: begin
          if (lc_len == LW'(WL)) begin
            status_d = turn_q ? ST_O_WON : ST_X_WON;
            win_d    = '0;
            for (int k = 0; k < WL; k++) begin
              wr = int'(lc_start_row) + k * DIR_DR[dir_q];
              wc = int'(lc_start_col) + k * DIR_DC[dir_q];
              win_d[IW'(wr * NI + wc)] = 1'b1;
            end
            state_d = S_OVER;
          end else if (dir_q == DIR_LAST) begin
            if (cnt_q == CNW'(NN)) begin
              status_d = ST_DRAW;
              state_d  = S_OVER;
            end else begin
              turn_d  = ~turn_q;
              state_d = S_IDLE;
            end
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end
        default: begin
          state_d = S_OVER;
        end
      endcase
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cells_q   <= '{default: CELL_EMPTY};
      turn_q    <= 1'b0;
      status_q  <= ST_PLAYING;
      illegal_q <= 1'b0;
      win_q     <= '0;
      ready_q   <= 1'b1;
      mv_row_q  <= '0;
      mv_col_q  <= '0;
      cnt_q     <= '0;
      dir_q     <= '0;
`ifdef BGC_UNDO_EN
      undo_avail_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      turn_q    <= turn_d;
      status_q  <= status_d;
      illegal_q <= illegal_d;
      win_q     <= win_d;
      ready_q   <= ready_d;
      mv_row_q  <= mv_row_d;
      mv_col_q  <= mv_col_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
`ifdef BGC_UNDO_EN
      undo_avail_q <= undo_avail_d;
`endif
    end
  end

endmodule

// File: tb/tb_board_game_ctrl.sv
// Directed bench for board_game_ctrl: a 3x3 (K=3) and a 5x5 (K=4) instance side by side.
module tb_board_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ng3, mv3, undo3, rdy3, turn3, ill3;
  logic [1:0]  row3, col3, st3;
  logic [17:0] board3;
  logic [8:0]  win3;

  logic        ng5, mv5, undo5, rdy5, turn5, ill5;
  logic [2:0]  row5, col5;
  logic [1:0]  st5;
  logic [49:0] board5;
  logic [24:0] win5;

  board_game_ctrl #(.N(3), .WIN_LEN(3)) dut3 (
    .clk(clk), .reset(reset), .new_game(ng3),
`ifdef BGC_UNDO_EN
    .undo(undo3),
`endif
    .move_valid(mv3), .move_ready(rdy3), .move_row(row3), .move_col(col3),
    .board(board3), .turn(turn3), .status(st3), .illegal(ill3), .win_cells(win3)
  );

  board_game_ctrl #(.N(5), .WIN_LEN(4)) dut5 (
    .clk(clk), .reset(reset), .new_game(ng5),
`ifdef BGC_UNDO_EN
    .undo(undo5),
`endif
    .move_valid(mv5), .move_ready(rdy5), .move_row(row5), .move_col(col5),
    .board(board5), .turn(turn5), .status(st5), .illegal(ill5), .win_cells(win5)
  );

  int total = 0;
  int bad = 0;
  logic [17:0] exp3;
  logic [49:0] exp5;
  logic tn3, tn5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Legal non-winning move on the 3x3 board, followed by the full scan
  task automatic play3(input int r, input int c);
    mv3 = 1'b1; row3 = 2'(r); col3 = 2'(c);
    tick();
    mv3 = 1'b0;
    exp3[2*(r*3+c) +: 2] = tn3 ? 2'b10 : 2'b01;
    check("p3_board", 64'(board3), 64'(exp3));
    check("p3_busy", 64'(rdy3), 64'd0);
    repeat (4) tick();
    tn3 = ~tn3;
    check("p3_turn", 64'(turn3), 64'(tn3));
    check("p3_ready", 64'(rdy3), 64'd1);
    check("p3_status", 64'(st3), 64'd0);
  endtask

  task automatic play5(input int r, input int c);
    mv5 = 1'b1; row5 = 3'(r); col5 = 3'(c);
    tick();
    mv5 = 1'b0;
    exp5[2*(r*5+c) +: 2] = tn5 ? 2'b10 : 2'b01;
    check("p5_board", 64'(board5), 64'(exp5));
    repeat (4) tick();
    tn5 = ~tn5;
    check("p5_turn", 64'(turn5), 64'(tn5));
    check("p5_ready", 64'(rdy5), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    ng3 = 1'b0; mv3 = 1'b0; undo3 = 1'b0; row3 = '0; col3 = '0;
    ng5 = 1'b0; mv5 = 1'b0; undo5 = 1'b0; row5 = '0; col5 = '0;
    exp3 = '0; exp5 = '0; tn3 = 1'b0; tn5 = 1'b0;
    repeat (2) tick();
    check("rst_board", 64'(board3), 64'd0);
    check("rst_turn", 64'(turn3), 64'd0);
    check("rst_status", 64'(st3), 64'd0);
    check("rst_illegal", 64'(ill3), 64'd0);
    check("rst_win", 64'(win3), 64'd0);
    check("rst_ready", 64'(rdy3), 64'd1);
    check("rst_ready5", 64'(rdy5), 64'd1);
    reset = 1'b1;
    tick();

    // Row-0 win for X on 3x3
    play3(0, 0);
    play3(1, 0);
    play3(0, 1);
    play3(1, 1);
    mv3 = 1'b1; row3 = 2'd0; col3 = 2'd2;
    tick();
    mv3 = 1'b0;
    exp3[5:4] = 2'b01;
    check("win_board", 64'(board3), 64'(exp3));
    check("win_not_yet", 64'(st3), 64'd0);
    tick();
    check("win_status", 64'(st3), 64'd1);
    check("win_cells", 64'(win3), 64'h007);
    check("win_ready", 64'(rdy3), 64'd0);
    repeat (3) tick();
    check("win_hold", 64'(st3), 64'd1);

    // new_game clears, and beats a same-cycle move
    ng3 = 1'b1; mv3 = 1'b1; row3 = 2'd0; col3 = 2'd0;
    tick();
    ng3 = 1'b0; mv3 = 1'b0;
    exp3 = '0; tn3 = 1'b0;
    check("ng_board", 64'(board3), 64'd0);
    check("ng_status", 64'(st3), 64'd0);
    check("ng_win", 64'(win3), 64'd0);
    check("ng_ready", 64'(rdy3), 64'd1);

    // Occupied and out-of-range moves are rejected
    play3(1, 1);
    mv3 = 1'b1; row3 = 2'd1; col3 = 2'd1;
    tick();
    mv3 = 1'b0;
    check("occ_illegal", 64'(ill3), 64'd1);
    check("occ_board", 64'(board3), 64'(exp3));
    check("occ_turn", 64'(turn3), 64'd1);
    check("occ_ready", 64'(rdy3), 64'd1);
    tick();
    check("occ_pulse_end", 64'(ill3), 64'd0);
    mv3 = 1'b1; row3 = 2'd3; col3 = 2'd0;
    tick();
    mv3 = 1'b0;
    check("oor_illegal", 64'(ill3), 64'd1);
    check("oor_board", 64'(board3), 64'(exp3));
    tick();

    // Full board without a line: draw
    ng3 = 1'b1;
    tick();
    ng3 = 1'b0;
    exp3 = '0; tn3 = 1'b0;
    play3(0, 0); play3(0, 1); play3(0, 2); play3(1, 1);
    play3(1, 0); play3(1, 2); play3(2, 1); play3(2, 0);
    mv3 = 1'b1; row3 = 2'd2; col3 = 2'd2;
    tick();
    mv3 = 1'b0;
    exp3[17:16] = 2'b01;
    check("draw_board", 64'(board3), 64'(exp3));
    repeat (3) tick();
    check("draw_not_yet", 64'(st3), 64'd0);
    tick();
    check("draw_status", 64'(st3), 64'd3);
    check("draw_win", 64'(win3), 64'd0);
    check("draw_ready", 64'(rdy3), 64'd0);

    // 5x5, K=4: O wins on the anti-diagonal, found on the last direction
    play5(0, 0); play5(0, 4); play5(0, 1); play5(1, 3);
    play5(4, 4); play5(2, 2); play5(2, 0);
    mv5 = 1'b1; row5 = 3'd3; col5 = 3'd1;
    tick();
    mv5 = 1'b0;
    exp5[2*16 +: 2] = 2'b10;
    check("anti_board", 64'(board5), 64'(exp5));
    repeat (3) tick();
    check("anti_not_yet", 64'(st5), 64'd0);
    tick();
    check("anti_status", 64'(st5), 64'd2);
    check("anti_cells", 64'(win5), 64'h0011110);
    mv5 = 1'b1; row5 = 3'd4; col5 = 3'd3;
    tick();
    mv5 = 1'b0;
    check("over_illegal", 64'(ill5), 64'd0);
    check("over_board", 64'(board5), 64'(exp5));
    check("over_ready", 64'(rdy5), 64'd0);
    check("over_status", 64'(st5), 64'd2);

    // new_game abandons an in-progress scan
    ng5 = 1'b1;
    tick();
    ng5 = 1'b0;
    mv5 = 1'b1; row5 = 3'd2; col5 = 3'd2;
    tick();
    mv5 = 1'b0;
    check("scan_placed", 64'(board5), 64'd1 << 24);
    ng5 = 1'b1;
    tick();
    ng5 = 1'b0;
    check("abort_board", 64'(board5), 64'd0);
    check("abort_turn", 64'(turn5), 64'd0);
    check("abort_status", 64'(st5), 64'd0);
    check("abort_ready", 64'(rdy5), 64'd1);
    repeat (4) tick();
    check("abort_turn_late", 64'(turn5), 64'd0);

`ifdef BGC_UNDO_EN
    // Single-depth undo
    ng3 = 1'b1;
    tick();
    ng3 = 1'b0;
    exp3 = '0; tn3 = 1'b0;
    play3(0, 0);
    undo3 = 1'b1;
    tick();
    undo3 = 1'b0;
    check("undo_board", 64'(board3), 64'd0);
    check("undo_turn", 64'(turn3), 64'd0);
    undo3 = 1'b1;
    tick();
    undo3 = 1'b0;
    check("undo2_board", 64'(board3), 64'd0);
    check("undo2_turn", 64'(turn3), 64'd0);
`endif

    // Asynchronous reset in the middle of a scan
    ng3 = 1'b1;
    tick();
    ng3 = 1'b0;
    mv3 = 1'b1; row3 = 2'd2; col3 = 2'd2;
    tick();
    mv3 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_board", 64'(board3), 64'd0);
    check("arst_ready", 64'(rdy3), 64'd1);
    check("arst_turn", 64'(turn3), 64'd0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("arst_status", 64'(st3), 64'd0);
    check("arst_turn_late", 64'(turn3), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_game_ctrl.md
# board_game_ctrl

Parametrised two-player N×N board game controller, the successor to the fixed 3×3 tic-tac-toe game controller and win detector pair. It accepts moves through a valid/ready handshake and rejects illegal moves. After each move it runs a sequential K-in-a-row win scan around the placed cell, then reports win or draw. It sits between the keypad submission logic and the seven-segment display driver, and exports the full board plus game status.

## Interface
- `N`, 3: board side length, legal range 3..8.
- `WIN_LEN`, 3: run length needed to win, legal range 3..N.
- `CW`, `$clog2(N)`: coordinate width (derived, not overridden).

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `new_game` in 1: synchronous clear of board, turn and status; wins over a same-cycle move.
- `move_valid` in 1: move request.
- `move_ready` out 1: controller can accept a move.
- `move_row` in CW: row, 0 = top.
- `move_col` in CW: column, 0 = left.
- `board` out 2·N·N: cell (r,c) at bits [2(r·N+c)+1 : 2(r·N+c)]; 00 empty, 01 X, 10 O.
- `turn` out 1: player to move; 0 = X, 1 = O.
- `status` out 2: 00 playing, 01 X won, 10 O won, 11 draw.
- `illegal` out 1: one-cycle pulse on a rejected move.
- `win_cells` out N·N: one-hot mask of the winning run; zero otherwise.

## Operation
- Reset values: board all 0, turn 0, status 00, illegal 0, win_cells 0, move_ready 1, state IDLE, move count 0.
- FSM states: IDLE, SCAN, OVER.
- **IDLE:** `move_ready` = 1. A move is accepted when `move_valid` && `move_ready`.
  - Legal move (coordinates < N and cell empty): write `turn+1` to the cell, latch coordinates, increment move count, clear the direction counter, go to SCAN.
  - Illegal move (out of range or occupied): board unchanged, `illegal` pulses next cycle, turn kept, stay in IDLE.
- **SCAN:** `move_ready` = 0. One direction per cycle, in the order horizontal, vertical, diagonal, anti-diagonal.
  - Each cycle counts same-player cells contiguous with the placed cell, up to WIN_LEN−1 steps each way, stopping at the board edge.
  - Total including the placed cell ≥ WIN_LEN → status = player, latch `win_cells` (the first WIN_LEN cells of the run, lowest index first), go to OVER.
  - After direction 3 with no win: if move count = N·N → status 11, go to OVER; otherwise toggle turn and return to IDLE.
- **OVER:** `move_ready` = 0; moves are ignored, with no `illegal` pulse. Only `new_game` or `reset` leaves OVER.
- `new_game` in any state: IDLE, board 0, turn 0, status 00, count 0, win_cells 0, next cycle. A SCAN in progress is abandoned.
- Move count width is `$clog2(N·N+1)`; it never wraps because play stops at N·N.

## Timing
- Move accepted at edge T → board visible at T+1.
- Win found in direction d (0..3) → status updates at T+2+d.
- No win → turn toggles and `move_ready` returns at T+5.
- `illegal` is high for exactly cycle T+1.
- Minimum spacing between accepted moves: 5 cycles.
- Reset asserted mid-SCAN: all outputs return to reset values asynchronously; no partial status update.

## Configuration
- `BGC_UNDO_EN` defined:
  - Adds input `undo` (1 bit). Honoured only in IDLE with status 00 and at least one move made.
  - Effect: clears the last placed cell, decrements the move count, toggles turn back.
  - Depth is one; a second consecutive undo is ignored until a new move is accepted.
  - `new_game` overrides `undo`.
- `BGC_UNDO_EN` undefined: no `undo` port and no last-move history registers.

## Structure
- Package `board_game_pkg` holds:
  - cell encodings (EMPTY, X, O);
  - status encodings;
  - FSM state enum;
  - direction delta constants (dr, dc) for the 4 directions.
- Sub-module `bgc_line_count`: combinational count along one direction. Inputs are board, origin, direction and player; output is the run length saturated at WIN_LEN plus the run start cell.
- Top level holds the FSM, registers and handshake.

## Test plan
- N=3, WIN_LEN=3: X(0,0), O(1,0), X(0,1), O(1,1), X(0,2) → status 01 at T+2 after the last accept, win_cells = 0x007, OVER.
- N=3: occupy (1,1), then request (1,1) again → `illegal` pulse, board and turn unchanged, `move_ready` stays 1.
- N=3: fill the board with no line (X: 0,2,3,7,8; O: 1,4,5,6 in play order) → status 11 at T+5 after the ninth move.
- N=5, WIN_LEN=4: O completes anti-diagonal (0,4)(1,3)(2,2)(3,1) with (3,1) last → status 10 at T+5; a move during OVER is ignored with no `illegal`.
- Assert `new_game` during SCAN after X plays (2,2) on N=5 → board 0, turn 0, status 00 next cycle. With `BGC_UNDO_EN`: play X(0,0), undo → cell 0 empty, turn 0; a second undo has no effect.
